// File: rtl/pencoder_pkg.sv
// Shared types and helpers for the serial priority-encoder stream.
//   idx_w(width)   : index width for a given bitmask width ($clog2 wrapper)
//   penc_state_t   : stream FSM states (IDLE, EMIT)
//   PENC_MAX_WIDTH : largest supported bitmask width
package pencoder_pkg;

  localparam int unsigned PENC_MAX_WIDTH = 64;

  typedef enum logic {
    IDLE,
    EMIT
  } penc_state_t;

  function automatic int unsigned idx_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/pencoder_tree.sv
// Combinational priority encoder built by recursive halving.
// Bit WIDTH-1 has the highest priority and maps to index 0; bit i maps to
// index WIDTH-1-i.
// Ports:
//   mask   in  WIDTH  bitmask to encode
//   idx    out IDX_W  priority index of the highest-priority set bit
//   any    out 1      at least one bit of mask is set
//   onehot out WIDTH  one-hot of the selected bit (all-zero when !any)
module pencoder_tree
  import pencoder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  if (WIDTH == 2) begin : g_leaf
    always_comb begin
      any    = |mask;
      idx    = ~mask[1];
      onehot = mask[1] ? 2'b10 : {1'b0, mask[0]};
    end
  end else begin : g_split
    localparam int unsigned HALF = WIDTH / 2;

    logic [IDX_W-2:0] hi_idx, lo_idx;
    logic             hi_any, lo_any;
    logic [HALF-1:0]  hi_onehot, lo_onehot;

    pencoder_tree #(.WIDTH(HALF)) u_hi (
      .mask   (mask[WIDTH-1:HALF]),
      .idx    (hi_idx),
      .any    (hi_any),
      .onehot (hi_onehot)
    );

    pencoder_tree #(.WIDTH(HALF)) u_lo (
      .mask   (mask[HALF-1:0]),
      .idx    (lo_idx),
      .any    (lo_any),
      .onehot (lo_onehot)
    );

    // Upper half wins; its indices occupy the lower half of the index range.
    always_comb begin
      any = hi_any | lo_any;
      if (hi_any) begin
        idx    = {1'b0, hi_idx};
        onehot = {hi_onehot, {HALF{1'b0}}};
      end else begin
        idx    = {1'b1, lo_idx};
        onehot = {{HALF{1'b0}}, lo_onehot};
      end
    end
  end

endmodule

// File: rtl/pencoder_serial_stream.sv
// Serialising priority encoder: accepts a WIDTH-bit mask over valid/ready and
// emits the index of every set bit, highest priority (bit WIDTH-1 -> index 0)
// first, one beat per cycle. An all-zero mask yields one out_zero beat.
// Optional feature macro: PENC_POPCNT_EN adds out_cnt (set bits remaining,
// including the current beat).
// Ports:
//   clk        in   1        clock
//   reset      in   1        asynchronous active-low reset
//   in_valid   in   1        in_mask is valid
//   in_ready   out  1        mask can be accepted this cycle
//   in_mask    in   WIDTH    bitmask to serialise
//   out_valid  out  1        beat outputs are valid
//   out_ready  in   1        downstream accepts the current beat
//   out_idx    out  IDX_W    priority index of the current set bit
//   out_last   out  1        final beat of this mask
//   out_zero   out  1        mask was all-zero
//   out_cnt    out  IDX_W+1  (PENC_POPCNT_EN only) set bits remaining
module pencoder_serial_stream
  import pencoder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
`ifdef PENC_POPCNT_EN
  ,
  output logic [IDX_W:0]   out_cnt
`endif
);

  penc_state_t      state, state_nx;
  logic [WIDTH-1:0] work;        // mask still to report, including the current bit
  logic [WIDTH-1:0] cur_onehot;  // bit reported by the current beat
  logic [WIDTH-1:0] nx_mask;
  logic             fire, fire_last, load, advance;

  logic [IDX_W-1:0] t_idx;
  logic             t_any;
  logic [WIDTH-1:0] t_onehot;

  // The encoder looks at the mask that will be current next cycle, so the
  // beat outputs can be registered without an extra cycle of latency.
  pencoder_tree #(.WIDTH(WIDTH)) u_tree (
    .mask   (nx_mask),
    .idx    (t_idx),
    .any    (t_any),
    .onehot (t_onehot)
  );

  assign out_valid = (state == EMIT);

  always_comb begin
    fire      = out_valid & out_ready;
    fire_last = fire & out_last;
    in_ready  = (state == IDLE) | fire_last;
    load      = in_valid & in_ready;
    advance   = load | (fire & ~out_last);
    nx_mask   = load ? in_mask : (work & ~cur_onehot);
    state_nx  = state;
    unique case (state)
      IDLE: if (load) state_nx = EMIT;
      EMIT: if (fire_last) state_nx = load ? EMIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work       <= '0;
      cur_onehot <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_zero   <= 1'b0;
    end else if (advance) begin
      work       <= nx_mask;
      cur_onehot <= t_onehot;
      out_idx    <= t_any ? t_idx : '0;
      out_last   <= ((nx_mask & ~t_onehot) == '0);
      out_zero   <= ~t_any;
    end else if (fire_last) begin
      work       <= '0;
      cur_onehot <= '0;
    end
  end

`ifdef PENC_POPCNT_EN
  logic [IDX_W:0] in_pop;

  always_comb begin
    in_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      in_pop = in_pop + (IDX_W+1)'(in_mask[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       out_cnt <= '0;
    else if (load)    out_cnt <= in_pop;
    else if (advance) out_cnt <= out_cnt - 1'b1;
  end
`endif

endmodule

// File: tb/tb_pencoder_serial_stream.sv
module tb_pencoder_serial_stream;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_zero;
  logic [15:0] in_mask;
  logic [3:0]  out_idx;

  logic        v64, r64, ov64, or64, last64, zero64;
  logic [63:0] mask64;
  logic [5:0]  idx64;

`ifdef PENC_POPCNT_EN
  logic [4:0]  out_cnt;
  logic [6:0]  cnt64;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pencoder_serial_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero)
`ifdef PENC_POPCNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  pencoder_serial_stream #(.WIDTH(64)) dut64 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v64),
    .in_ready  (r64),
    .in_mask   (mask64),
    .out_valid (ov64),
    .out_ready (or64),
    .out_idx   (idx64),
    .out_last  (last64),
    .out_zero  (zero64)
`ifdef PENC_POPCNT_EN
    ,
    .out_cnt   (cnt64)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b1;
    v64 = 1'b0; mask64 = '0; or64 = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_idx",   out_idx, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_zero",  out_zero, 0);
    chk("rst_v64",   ov64, 0);
`ifdef PENC_POPCNT_EN
    chk("rst_cnt",   out_cnt, 0);
`endif
    step();
    reset = 1'b1;
    step();

    // 8001: idx 0 then 15
    in_valid = 1'b1; in_mask = 16'h8001;
    chk("t1_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0; in_mask = 16'h1234;
    chk("t1_b0_valid", out_valid, 1);
    chk("t1_b0_idx",   out_idx, 0);
    chk("t1_b0_last",  out_last, 0);
    chk("t1_b0_ready", in_ready, 0);
`ifdef PENC_POPCNT_EN
    chk("t1_b0_cnt",   out_cnt, 2);
`endif
    step();
    chk("t1_b1_idx",   out_idx, 15);
    chk("t1_b1_last",  out_last, 1);
    chk("t1_b1_ready", in_ready, 1);
`ifdef PENC_POPCNT_EN
    chk("t1_b1_cnt",   out_cnt, 1);
`endif
    step();
    chk("t1_done_valid", out_valid, 0);
    chk("t1_done_ready", in_ready, 1);

    // zero mask
    in_valid = 1'b1; in_mask = 16'h0000;
    step();
    in_valid = 1'b0;
    chk("t2_valid", out_valid, 1);
    chk("t2_zero",  out_zero, 1);
    chk("t2_idx",   out_idx, 0);
    chk("t2_last",  out_last, 1);
`ifdef PENC_POPCNT_EN
    chk("t2_cnt",   out_cnt, 0);
`endif
    step();
    chk("t2_done_valid", out_valid, 0);

    // FFFF with alternating stalls; input changes ignored while busy
    in_valid = 1'b1; in_mask = 16'hFFFF; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_mask = 16'(k * 16'h1111);
      chk("t3_valid", out_valid, 1);
      chk("t3_idx",   out_idx, k);
      chk("t3_last",  out_last, (k == 15));
      chk("t3_zero",  out_zero, 0);
`ifdef PENC_POPCNT_EN
      chk("t3_cnt",   out_cnt, 16 - k);
`endif
      step();
      chk("t3_hold_idx",  out_idx, k);
      chk("t3_hold_last", out_last, (k == 15));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("t3_done_valid", out_valid, 0);
    out_ready = 1'b1;

    // back-to-back
    in_valid = 1'b1; in_mask = 16'h0100;
    step();
    in_mask = 16'h0002;
    chk("t4_a_idx",   out_idx, 7);
    chk("t4_a_last",  out_last, 1);
    chk("t4_a_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t4_b_valid", out_valid, 1);
    chk("t4_b_idx",   out_idx, 14);
    chk("t4_b_last",  out_last, 1);
    step();
    chk("t4_done_valid", out_valid, 0);

    // reset mid-stream
    in_valid = 1'b1; in_mask = 16'hF0F0;
    step();
    in_valid = 1'b0;
    chk("t5_b0_idx", out_idx, 0);
    step();
    chk("t5_b1_idx", out_idx, 1);
    step();
    chk("t5_b2_idx", out_idx, 2);
    reset = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    step();
    reset = 1'b1;
    chk("t5_rel_ready", in_ready, 1);
    chk("t5_rel_valid", out_valid, 0);
    step();
    chk("t5_idle_valid", out_valid, 0);
    in_valid = 1'b1; in_mask = 16'h0004;
    step();
    in_valid = 1'b0;
    chk("t5_n_idx",  out_idx, 13);
    chk("t5_n_last", out_last, 1);
    step();
    chk("t5_n_done", out_valid, 0);

    // WIDTH=64
    v64 = 1'b1; mask64 = 64'h8000_0000_0000_0001;
    step();
    v64 = 1'b0;
    chk("t6_b0_valid", ov64, 1);
    chk("t6_b0_idx",   idx64, 0);
    chk("t6_b0_last",  last64, 0);
`ifdef PENC_POPCNT_EN
    chk("t6_b0_cnt",   cnt64, 2);
`endif
    step();
    chk("t6_b1_idx",   idx64, 63);
    chk("t6_b1_last",  last64, 1);
`ifdef PENC_POPCNT_EN
    chk("t6_b1_cnt",   cnt64, 1);
`endif
    step();
    chk("t6_done_valid", ov64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
